// File: rtl/cmd_framer_pkg.sv
// Shared op codes and state encodings for the command framer and its monitor.
package cmd_framer_pkg;

  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_DUMP = 2'd2;
  localparam logic [1:0] OP_EXEC = 2'd3;

  localparam logic [2:0] ST_HDR0    = 3'd0;
  localparam logic [2:0] ST_HDR1    = 3'd1;
  localparam logic [2:0] ST_HDR2    = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_PAYLOAD = 3'd5;

  function automatic logic [7:0] hdr_csum(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/cmd_framer_if.sv
// Decoded-command and payload bus between the framer (master) and its consumer.
interface cmd_framer_if;
  logic        cmd_valid;
  logic        cmd_ack;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [5:0]  cmd_len;
  logic [7:0]  data_byte;
  logic        data_valid;

  modport master (output cmd_valid, cmd_op, cmd_addr, cmd_len, data_byte, data_valid,
                  input  cmd_ack);
  modport slave  (input  cmd_valid, cmd_op, cmd_addr, cmd_len, data_byte, data_valid,
                  output cmd_ack);
endinterface

// File: rtl/cmd_framer_idle_timer.sv
// Inter-byte idle timer; expired fires on the TIMEOUT_CYCLES-th consecutive enabled idle clock.
module idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  // A byte in the same clock as the limit counts as activity, not a timeout.
  assign expired = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || expired) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/cmd_framer.sv
// UART command framer: 3-byte header (addr hi, addr lo, op/len), handshake, LOAD payload.
// Optional header checksum byte enabled by defining CMD_FRAMER_CHECKSUM_EN.
module cmd_framer
  import cmd_framer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_byte,
  input  logic         received,
  input  logic         recv_error,
  cmd_framer_if.master bus,
  output logic         frame_error,
  output logic         overrun
);
  logic [2:0]  state;
  logic [1:0]  op_q;
  logic [15:0] addr_q;
  logic [5:0]  len_q;
  logic [5:0]  count;
  logic [7:0]  data_q;
  logic        dv_q;
  logic        idle_en;
  logic        expired;
`ifdef CMD_FRAMER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign idle_en = (state == ST_HDR1) || (state == ST_HDR2) ||
                   (state == ST_CSUM) || (state == ST_PAYLOAD);

  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle (
    .clk     (clk),
    .rst     (rst),
    .clear   (received || recv_error),
    .enable  (idle_en),
    .expired (expired)
  );

  assign bus.cmd_valid  = (state == ST_HOLD);
  assign bus.cmd_op     = op_q;
  assign bus.cmd_addr   = addr_q;
  assign bus.cmd_len    = len_q;
  assign bus.data_byte  = data_q;
  assign bus.data_valid = dv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HDR0;
      op_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      count       <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef CMD_FRAMER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      dv_q        <= 1'b0;
      // HOLD ignores recv_error and drops bytes; the header must stay stable until ack.
      if (state == ST_HOLD) begin
        if (received) overrun <= 1'b1;
        if (bus.cmd_ack) begin
          if (op_q == OP_LOAD && len_q != '0) begin
            state <= ST_PAYLOAD;
            count <= len_q;
          end else begin
            state <= ST_HDR0;
          end
        end
      end else if (recv_error || expired) begin
        frame_error <= 1'b1;
        state       <= ST_HDR0;
      end else if (received) begin
        case (state)
          ST_HDR0: begin
            addr_q[15:8] <= rx_byte;
            state        <= ST_HDR1;
          end
          ST_HDR1: begin
            addr_q[7:0] <= rx_byte;
            state       <= ST_HDR2;
          end
          ST_HDR2: begin
            if (rx_byte[7:6] == 2'b00) begin
              frame_error <= 1'b1;
              state       <= ST_HDR0;
            end else begin
              op_q  <= rx_byte[7:6];
              len_q <= rx_byte[5:0];
`ifdef CMD_FRAMER_CHECKSUM_EN
              csum_q <= hdr_csum(addr_q[15:8], addr_q[7:0], rx_byte);
              state  <= ST_CSUM;
`else
              state <= ST_HOLD;
`endif
            end
          end
`ifdef CMD_FRAMER_CHECKSUM_EN
          ST_CSUM: begin
            if (rx_byte == csum_q) begin
              state <= ST_HOLD;
            end else begin
              frame_error <= 1'b1;
              state       <= ST_HDR0;
            end
          end
`endif
          ST_PAYLOAD: begin
            data_q <= rx_byte;
            dv_q   <= 1'b1;
            count  <= count - 6'd1;
            if (count == 6'd1) state <= ST_HDR0;
          end
          default: state <= ST_HDR0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmd_framer.sv
// Self-checking bench for cmd_framer: frame-level reference model plus directed vectors.
module tb_cmd_framer;
  import cmd_framer_pkg::*;

  localparam int unsigned TMO = 100;
`ifdef CMD_FRAMER_CHECKSUM_EN
  localparam int HDR_N = 4;
`else
  localparam int HDR_N = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = '0;
  logic       received = 1'b0;
  logic       recv_error = 1'b0;
  logic       ack = 1'b0;
  logic       fe;
  logic       ov;

  cmd_framer_if bus ();
  assign bus.cmd_ack = ack;

  cmd_framer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_byte     (rx_byte),
    .received    (received),
    .recv_error  (recv_error),
    .bus         (bus),
    .frame_error (fe),
    .overrun     (ov)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int dv_cnt = 0;
  logic [7:0] dq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes accumulate into a header list; a full header is held until
  // acknowledged; LOAD then owes len payload bytes; TMO consecutive idle cycles abort.
  logic [7:0]  m_hdr [0:3];
  int          m_n, m_rem, m_idle;
  bit          m_hold;
  logic [1:0]  m_op;
  logic [15:0] m_addr;
  logic [5:0]  m_len;
  bit          e_fe, e_ov, e_dv;
  logic [7:0]  e_db;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_n = 0; m_rem = 0; m_idle = 0; m_hold = 0;
        e_fe = 0; e_ov = 0; e_dv = 0;
      end else begin
        e_fe = 0; e_ov = 0; e_dv = 0;
        if (m_hold) begin
          if (received) e_ov = 1;
          if (ack) begin
            m_hold = 0;
            if (m_op == OP_LOAD) m_rem = int'(m_len);
          end
        end else if (recv_error) begin
          e_fe = 1; m_n = 0; m_rem = 0;
        end else if (received) begin
          m_idle = 0;
          if (m_rem > 0) begin
            e_dv = 1; e_db = rx_byte; m_rem--;
          end else begin
            m_hdr[m_n] = rx_byte;
            m_n++;
            if (m_n == 3 && m_hdr[2][7:6] == 2'b00) begin
              e_fe = 1; m_n = 0;
            end else if (m_n == HDR_N) begin
              m_n = 0;
              if (HDR_N == 4 && m_hdr[3] != (m_hdr[0] ^ m_hdr[1] ^ m_hdr[2])) begin
                e_fe = 1;
              end else begin
                m_hold = 1;
                m_op   = m_hdr[2][7:6];
                m_addr = {m_hdr[0], m_hdr[1]};
                m_len  = m_hdr[2][5:0];
              end
            end
          end
        end else if (m_n > 0 || m_rem > 0) begin
          m_idle++;
          if (m_idle == int'(TMO)) begin
            e_fe = 1; m_n = 0; m_rem = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cmd_valid", 32'(bus.cmd_valid), 32'(m_hold));
        chk("frame_error", 32'(fe), 32'(e_fe));
        chk("overrun", 32'(ov), 32'(e_ov));
        chk("data_valid", 32'(bus.data_valid), 32'(e_dv));
        if (m_hold) begin
          chk("cmd_op", 32'(bus.cmd_op), 32'(m_op));
          chk("cmd_addr", 32'(bus.cmd_addr), 32'(m_addr));
          chk("cmd_len", 32'(bus.cmd_len), 32'(m_len));
        end
        if (e_dv) chk("data_byte", 32'(bus.data_byte), 32'(e_db));
        if (fe) fe_cnt++;
        if (bus.data_valid) begin
          dv_cnt++;
          dq.push_back(bus.data_byte);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
`ifdef CMD_FRAMER_CHECKSUM_EN
    send_byte(b0 ^ b1 ^ b2);
`endif
  endtask

  task automatic ack_once();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.cmd_valid), 32'h0);
    chk({tag, "_dv"},    32'(bus.data_valid), 32'h0);
    chk({tag, "_fe"},    32'(fe), 32'h0);
    chk({tag, "_ov"},    32'(ov), 32'h0);
    chk({tag, "_addr"},  32'(bus.cmd_addr), 32'h0);
    chk({tag, "_op"},    32'(bus.cmd_op), 32'h0);
    chk({tag, "_len"},   32'(bus.cmd_len), 32'h0);
    chk({tag, "_db"},    32'(bus.data_byte), 32'h0);
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int d0;
    repeat (3) @(negedge clk);
    chk_rst_outputs("reset");
    rst = 1'b0;
    idle(2);

    // ack with nothing pending must be harmless
    ack_once();
    idle(2);
    chk("stray_ack", 32'(bus.cmd_valid), 32'h0);

    // LOAD addr 0x0010 len 2, payload AA BB
    send_hdr(8'h00, 8'h10, 8'h42);
    chk("load_latency", 32'(bus.cmd_valid), 32'h1);
    chk("load_op", 32'(bus.cmd_op), 32'h1);
    chk("load_addr", 32'(bus.cmd_addr), 32'h0010);
    chk("load_len", 32'(bus.cmd_len), 32'h2);
    idle(2);
    ack_once();
    dq.delete();
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(2);
    chk("load_count", 32'(dq.size()), 32'h2);
    if (dq.size() == 2) begin
      chk("load_d0", 32'(dq[0]), 32'hAA);
      chk("load_d1", 32'(dq[1]), 32'hBB);
    end

    // DUMP held unacknowledged; extra byte is an overrun
    send_hdr(8'h00, 8'h20, 8'h83);
    idle(5);
    send_byte(8'h55);
    chk("ovr_pulse", 32'(ov), 32'h1);
    chk("ovr_valid", 32'(bus.cmd_valid), 32'h1);
    chk("ovr_addr", 32'(bus.cmd_addr), 32'h0020);
    ack_once();
    chk("dump_done", 32'(bus.cmd_valid), 32'h0);
    idle(2);

    // inter-byte timeout after two header bytes
    send_byte(8'h01);
    send_byte(8'h00);
    n = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (fe) begin
        n = i;
        break;
      end
    end
    chk("tmo_cycles", 32'(n), 32'd100);
    send_hdr(8'h01, 8'h00, 8'hC0);
    chk("exec_op", 32'(bus.cmd_op), 32'h3);
    chk("exec_addr", 32'(bus.cmd_addr), 32'h0100);
    ack_once();
    idle(2);

    // op 0 is rejected at the third byte
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h3F);
    chk("op0_fe", 32'(fe), 32'h1);
    chk("op0_valid", 32'(bus.cmd_valid), 32'h0);
    idle(2);

    // recv_error after one header byte
    send_byte(8'h7E);
    recv_error = 1'b1;
    @(negedge clk);
    recv_error = 1'b0;
    chk("rxerr_fe", 32'(fe), 32'h1);
    // error and byte together: error wins, byte discarded
    send_byte(8'h12);
    rx_byte = 8'h34; received = 1'b1; recv_error = 1'b1;
    @(negedge clk);
    received = 1'b0; recv_error = 1'b0;
    chk("collide_fe", 32'(fe), 32'h1);
    send_hdr(8'h00, 8'h30, 8'h41);
    chk("collide_addr", 32'(bus.cmd_addr), 32'h0030);
    ack_once();
    send_byte(8'h99);
    idle(2);

    // reset in the middle of a payload
    send_hdr(8'h00, 8'h40, 8'h45);
    ack_once();
    send_byte(8'h11);
    send_byte(8'h22);
    d0 = dv_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk_rst_outputs("midrst");
    rst = 1'b0;
    idle(10);
    chk("midrst_no_dv", 32'(dv_cnt - d0), 32'h0);
    send_hdr(8'h00, 8'h01, 8'h41);
    ack_once();
    send_byte(8'h5A);
    idle(1);
    chk("post_rst_data", 32'(dq[$]), 32'h5A);

`ifdef CMD_FRAMER_CHECKSUM_EN
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h81); send_byte(8'hA7);
    chk("csum_ok", 32'(bus.cmd_valid), 32'h1);
    ack_once();
    idle(2);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h81); send_byte(8'h00);
    chk("csum_bad", 32'(fe), 32'h1);
    idle(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmd_framer.md
CMD_FRAMER -- requirements
Module: cmd_framer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 12000000, max idle clocks between bytes of one frame before abort (1 s at 12 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_byte  input  8  byte from UART receiver.
REQ-005 SHALL have port received  input  1  one-cycle strobe: rx_byte valid.
REQ-006 SHALL have port recv_error  input  1  UART framing error strobe.
REQ-007 SHALL have port cmd_valid  output  1  decoded header available; held until acknowledged.
REQ-008 SHALL have port cmd_ack  input  1  consumer accepts header.
REQ-009 SHALL have port cmd_op  output  2  1=LOAD, 2=DUMP, 3=EXEC.
REQ-010 SHALL have port cmd_addr  output  16  {byte0, byte1}.
REQ-011 SHALL have port cmd_len  output  6  byte2[5:0].
REQ-012 SHALL have port data_byte / data_valid  output  8 / 1  LOAD payload byte with one-cycle strobe.
REQ-013 SHALL have port frame_error  output  1  one-cycle strobe on any aborted frame.
REQ-014 SHALL have port overrun  output  1  one-cycle strobe when a byte arrives while cmd_valid is high.

Function
REQ-015 States SHALL be HDR0, HDR1, HDR2, CSUM (macro only), HOLD, PAYLOAD.
REQ-016 HDR0 -> HDR1 -> HDR2 SHALL advance on each received strobe, capturing addr high, addr low, len/op bytes.
REQ-017 On the HDR2 byte, op = byte[7:6]; op 0 SHALL pulse frame_error and return to HDR0; otherwise go to HOLD (or CSUM).
REQ-018 In HOLD, cmd_valid SHALL be 1 with cmd_op/addr/len stable; transfer occurs in the cycle cmd_valid && cmd_ack.
REQ-019 On transfer: LOAD with len>0 SHALL go to PAYLOAD; every other case SHALL go to HDR0.
REQ-020 In PAYLOAD, each received strobe SHALL give data_byte = rx_byte and data_valid = 1 on the next cycle, decrementing a 6-bit count; when the count reaches 0, SHALL go to HDR0.
REQ-021 A received strobe in HOLD SHALL be dropped, pulse overrun, and leave state unchanged.
REQ-022 An idle counter SHALL clear on every received strobe and count in HDR1, HDR2, CSUM and PAYLOAD; when it reaches TIMEOUT_CYCLES-1, SHALL pulse frame_error and go to HDR0.
REQ-023 The idle counter SHALL be frozen in HDR0 and HOLD.
REQ-024 recv_error in any state except HOLD SHALL pulse frame_error and go to HDR0; in HOLD it SHALL be ignored.
REQ-025 recv_error and received in the same cycle: error SHALL win and the byte is discarded.
REQ-026 Latency SHALL be: cmd_valid rises one cycle after the final header strobe.
REQ-027 cmd_ack while cmd_valid=0 SHALL have no effect.

Reset
REQ-028 rst SHALL force state to HDR0, counters to 0, and cmd_valid, data_valid, frame_error, overrun to 0; cmd_addr, cmd_len, cmd_op, data_byte to 0.
REQ-029 rst asserted mid-frame or mid-payload SHALL discard all partial data with no strobe generated.

Configuration
REQ-030 With CMD_FRAMER_CHECKSUM_EN defined, HDR2 SHALL go to CSUM; the next byte SHALL equal byte0^byte1^byte2, else frame_error and HDR0; on match, go to HOLD.
REQ-031 Without CMD_FRAMER_CHECKSUM_EN, the CSUM state and its XOR register SHALL not exist, and HDR2 goes directly to HOLD.

Structure
REQ-032 The shared package SHALL hold the op codes (OP_LOAD=1, OP_DUMP=2, OP_EXEC=3) and the state encodings, shared with the monitor.
REQ-033 The idle timeout counter SHALL be a single sub-module, idle_timer (clear, enable, expired outputs).

Verification
REQ-034 Bytes 00,10,42 then ack -> cmd_valid with op=1, addr=0x0010, len=2; bytes AA,BB -> data_valid ×2 with AA,BB; state returns to HDR0.
REQ-035 Bytes 00,20,83, ack held low 5 cycles, then extra byte 55 -> overrun pulse, cmd_valid still high with addr=0x0020; after ack -> HDR0.
REQ-036 Bytes 01,00 then no further byte for TIMEOUT_CYCLES (set to 100 for the test) -> frame_error at cycle 100; next 01,00,C0 -> cmd_valid with op=3.
REQ-037 Byte 00,05,3F -> frame_error (op 0), no cmd_valid.
REQ-038 recv_error after 1 header byte -> frame_error and HDR0; rst during PAYLOAD -> no data_valid and all outputs 0.
REQ-039 With CMD_FRAMER_CHECKSUM_EN: 12,34,81,A7 -> cmd_valid; 12,34,81,00 -> frame_error.
